// File: rtl/uart_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: entry layout and widths.
package uart_buffer_pkg;

  // Each entry packs {parity type, parity enable, data}.
  function automatic int unsigned entry_width(input int unsigned data_width_log2);
    return (2 ** data_width_log2) + 2;
  endfunction

  // Bit offset of the data field within an entry.
  localparam int unsigned DataOffset = 0;

  // Bit offset of the parity-enable field within an entry.
  function automatic int unsigned par_en_offset(input int unsigned data_width_log2);
    return 2 ** data_width_log2;
  endfunction

  // Bit offset of the parity-type field within an entry.
  function automatic int unsigned par_type_offset(input int unsigned data_width_log2);
    return (2 ** data_width_log2) + 1;
  endfunction

endpackage

// File: rtl/uart_buffer_mem.sv
// Register-file storage for the transmit buffer: one synchronous write port,
// one asynchronous read port, and full clear on either reset.
module uart_buffer_mem
  import uart_buffer_pkg::*;
#(
  parameter int unsigned DataWIDTH  = 3,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_asyn_n,
  input  logic                                 i_flush_n,
  input  logic                                 i_we,
  input  logic [DEPTH_LOG2-1:0]                i_waddr,
  input  logic [entry_width(DataWIDTH)-1:0]    i_wdata,
  input  logic [DEPTH_LOG2-1:0]                i_raddr,
  output logic [entry_width(DataWIDTH)-1:0]    o_rdata
);

  localparam int unsigned EntryW = entry_width(DataWIDTH);
  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;

  logic [EntryW-1:0] r_mem [Depth];

  // Storage array: cleared by either reset, otherwise written on an accepted push.
  always_ff @(posedge i_clk or negedge i_rst_asyn_n) begin
    if (!i_rst_asyn_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (!i_flush_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo_buffer.sv
// Multi-entry FIFO in front of the UART transmitter. Each entry carries its own
// parity configuration; outputs are first-word-fall-through and gated to zero
// when empty.
module uart_tx_fifo_buffer
  import uart_buffer_pkg::*;
#(
  parameter int unsigned DataWIDTH  = 3,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                        Buffer_CLK,
  input  logic                        Buffer_RST_ASYN,
  input  logic                        Buffer_RST_SYN,
  input  logic                        Buffer_WR_EN,
  input  logic [(2**DataWIDTH)-1:0]   Buffer_Pdata_in,
  input  logic                        Buffer_ParityEn_in,
  input  logic                        Buffer_ParBit_in,
  input  logic                        Buffer_RD_EN,
  output logic [(2**DataWIDTH)-1:0]   Buffer_Pdata_out,
  output logic                        Buffer_ParityEn_out,
  output logic                        Buffer_ParBit_out,
  output logic                        Buffer_VALID,
  output logic                        Buffer_FULL,
  output logic [DEPTH_LOG2:0]         Buffer_COUNT,
  output logic                        Buffer_OVF
);

  localparam int unsigned DataW     = 2 ** DataWIDTH;
  localparam int unsigned EntryW    = entry_width(DataWIDTH);
  localparam int unsigned ParEnOff  = par_en_offset(DataWIDTH);
  localparam int unsigned ParTypOff = par_type_offset(DataWIDTH);
  localparam int unsigned Depth     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;

  logic              w_push_acc;
  logic              w_pop_acc;
  logic              w_valid;
  logic [EntryW-1:0] w_wdata;
  logic [EntryW-1:0] w_head;

  assign w_valid    = (r_count != '0);
  // Full/empty decisions use the pre-edge count, so a push while full is dropped
  // even when a pop frees a slot in the same cycle.
  assign w_push_acc = Buffer_WR_EN && (r_count != DepthCnt);
  assign w_pop_acc  = Buffer_RD_EN && w_valid;

  // Pack the incoming entry into its storage layout.
  always_comb begin
    w_wdata                          = '0;
    w_wdata[DataOffset +: DataW]     = Buffer_Pdata_in;
    w_wdata[ParEnOff]                = Buffer_ParityEn_in;
    w_wdata[ParTypOff]               = Buffer_ParBit_in;
  end

  uart_buffer_mem #(
    .DataWIDTH  (DataWIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .i_clk        (Buffer_CLK),
    .i_rst_asyn_n (Buffer_RST_ASYN),
    .i_flush_n    (Buffer_RST_SYN),
    .i_we         (w_push_acc),
    .i_waddr      (r_wr_ptr),
    .i_wdata      (w_wdata),
    .i_raddr      (r_rd_ptr),
    .o_rdata      (w_head)
  );

  // Pointers, occupancy and sticky overflow; sync flush outranks push/pop.
  always_ff @(posedge Buffer_CLK or negedge Buffer_RST_ASYN) begin
    if (!Buffer_RST_ASYN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (!Buffer_RST_SYN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      if (Buffer_WR_EN && !w_push_acc) r_ovf <= 1'b1;
      unique case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head outputs shown only while valid; all outputs derive from registered state.
  always_comb begin
    Buffer_Pdata_out    = '0;
    Buffer_ParityEn_out = 1'b0;
    Buffer_ParBit_out   = 1'b0;
    if (w_valid) begin
      Buffer_Pdata_out    = w_head[DataOffset +: DataW];
      Buffer_ParityEn_out = w_head[ParEnOff];
      Buffer_ParBit_out   = w_head[ParTypOff];
    end
  end

  assign Buffer_VALID = w_valid;
  assign Buffer_FULL  = (r_count == DepthCnt);
  assign Buffer_COUNT = r_count;
  assign Buffer_OVF   = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo_buffer.sv
// Directed self-checking bench for uart_tx_fifo_buffer at default parameters.
module tb_uart_tx_fifo_buffer;

  logic       clk;
  logic       rst_asyn;
  logic       rst_syn;
  logic       wr_en;
  logic [7:0] pdata_in;
  logic       paren_in;
  logic       parbit_in;
  logic       rd_en;
  logic [7:0] pdata_out;
  logic       paren_out;
  logic       parbit_out;
  logic       valid;
  logic       full;
  logic [2:0] count;
  logic       ovf;

  int checks;
  int errors;

  uart_tx_fifo_buffer #(
    .DataWIDTH  (3),
    .DEPTH_LOG2 (2)
  ) dut (
    .Buffer_CLK          (clk),
    .Buffer_RST_ASYN     (rst_asyn),
    .Buffer_RST_SYN      (rst_syn),
    .Buffer_WR_EN        (wr_en),
    .Buffer_Pdata_in     (pdata_in),
    .Buffer_ParityEn_in  (paren_in),
    .Buffer_ParBit_in    (parbit_in),
    .Buffer_RD_EN        (rd_en),
    .Buffer_Pdata_out    (pdata_out),
    .Buffer_ParityEn_out (paren_out),
    .Buffer_ParBit_out   (parbit_out),
    .Buffer_VALID        (valid),
    .Buffer_FULL         (full),
    .Buffer_COUNT        (count),
    .Buffer_OVF          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given request; inputs return to idle afterwards.
  task automatic cycle(input logic wr, input logic rd, input logic [7:0] d,
                       input logic pe, input logic pb);
    wr_en     = wr;
    rd_en     = rd;
    pdata_in  = d;
    paren_in  = pe;
    parbit_in = pb;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] head_of(input logic [7:0] d, input logic pe, input logic pb);
    return {22'd0, pb, pe, d};
  endfunction

  logic [31:0] head_now;
  always_comb head_now = {22'd0, parbit_out, paren_out, pdata_out};

  initial begin
    checks    = 0;
    errors    = 0;
    rst_asyn  = 1'b0;
    rst_syn   = 1'b1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    pdata_in  = '0;
    paren_in  = 1'b0;
    parbit_in = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en     = 1'($urandom);
      rd_en     = 1'($urandom);
      rst_syn   = 1'($urandom);
      pdata_in  = 8'($urandom);
      paren_in  = 1'($urandom);
      parbit_in = 1'($urandom);
    end
    #1;
    check_eq("rst_head",  head_now, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_full",  {31'd0, full}, 32'd0);
    check_eq("rst_count", {29'd0, count}, 32'd0);
    check_eq("rst_ovf",   {31'd0, ovf}, 32'd0);

    @(negedge clk);
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rst_syn  = 1'b1;
    rst_asyn = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("idle_head",  head_now, 32'd0);
    check_eq("idle_valid", {31'd0, valid}, 32'd0);
    check_eq("idle_count", {29'd0, count}, 32'd0);

    // Fill.
    cycle(1'b1, 1'b0, 8'hA1, 1'b1, 1'b0);
    check_eq("push1_valid", {31'd0, valid}, 32'd1);
    check_eq("push1_head",  head_now, head_of(8'hA1, 1'b1, 1'b0));
    cycle(1'b1, 1'b0, 8'hB2, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
    check_eq("push3_full", {31'd0, full}, 32'd0);
    cycle(1'b1, 1'b0, 8'hD4, 1'b1, 1'b1);
    check_eq("fill_full",  {31'd0, full}, 32'd1);
    check_eq("fill_count", {29'd0, count}, 32'd4);
    check_eq("fill_head",  head_now, head_of(8'hA1, 1'b1, 1'b0));
    check_eq("fill_ovf",   {31'd0, ovf}, 32'd0);

    // Overflow.
    cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    check_eq("ovf_flag",  {31'd0, ovf}, 32'd1);
    check_eq("ovf_count", {29'd0, count}, 32'd4);
    check_eq("ovf_head",  head_now, head_of(8'hA1, 1'b1, 1'b0));

    // Drain.
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("pop1_head",  head_now, head_of(8'hB2, 1'b1, 1'b1));
    check_eq("pop1_count", {29'd0, count}, 32'd3);
    check_eq("pop1_full",  {31'd0, full}, 32'd0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("pop2_head", head_now, head_of(8'hC3, 1'b1, 1'b0));
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("pop3_head", head_now, head_of(8'hD4, 1'b1, 1'b1));
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("pop4_valid", {31'd0, valid}, 32'd0);
    check_eq("pop4_head",  head_now, 32'd0);
    check_eq("pop4_count", {29'd0, count}, 32'd0);
    check_eq("pop4_ovf",   {31'd0, ovf}, 32'd1);

    // Pop while empty is ignored.
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("under_count", {29'd0, count}, 32'd0);
    check_eq("under_ovf",   {31'd0, ovf}, 32'd1);

    // Simultaneous push/pop at COUNT=2.
    cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    check_eq("sim_pre_count", {29'd0, count}, 32'd2);
    cycle(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    check_eq("sim_count", {29'd0, count}, 32'd2);
    check_eq("sim_head",  head_now, head_of(8'h22, 1'b1, 1'b0));
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("sim_pop_head", head_now, head_of(8'h33, 1'b0, 1'b1));
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("sim_empty", {31'd0, valid}, 32'd0);

    // Simultaneous push/pop while empty: only the push lands.
    cycle(1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
    check_eq("sim_e_count", {29'd0, count}, 32'd1);
    check_eq("sim_e_head",  head_now, head_of(8'h44, 1'b1, 1'b1));
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("sim_e_drain", {29'd0, count}, 32'd0);

    // Wrap-around with push/pop pairs.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      check_eq($sformatf("wrap_head%0d", i), head_now, head_of(8'(i), 1'b0, 1'b0));
      check_eq($sformatf("wrap_cnt%0d", i), {29'd0, count}, 32'd1);
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check_eq($sformatf("wrap_pop%0d", i), {29'd0, count}, 32'd0);
    end

    // Flush at COUNT=3 with OVF still set.
    cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    check_eq("fl_pre_count", {29'd0, count}, 32'd3);
    check_eq("fl_pre_ovf",   {31'd0, ovf}, 32'd1);
    rst_syn = 1'b0;
    cycle(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    rst_syn = 1'b1;
    check_eq("fl_count", {29'd0, count}, 32'd0);
    check_eq("fl_valid", {31'd0, valid}, 32'd0);
    check_eq("fl_ovf",   {31'd0, ovf}, 32'd0);
    check_eq("fl_head",  head_now, 32'd0);
    cycle(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    check_eq("fl_next_head",  head_now, head_of(8'h5A, 1'b1, 1'b0));
    check_eq("fl_next_count", {29'd0, count}, 32'd1);

    // Async reset mid-operation takes effect without a clock edge.
    cycle(1'b1, 1'b0, 8'h6B, 1'b0, 1'b0);
    @(negedge clk);
    rst_asyn = 1'b0;
    #1;
    check_eq("ar_count", {29'd0, count}, 32'd0);
    check_eq("ar_head",  head_now, 32'd0);
    @(negedge clk);
    rst_asyn = 1'b1;
    cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
    check_eq("ar_next_head",  head_now, head_of(8'h3C, 1'b0, 1'b1));
    check_eq("ar_next_count", {29'd0, count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
